oc_bank_arbiter: RTL and testbench
==================================

OC_BANK_ARBITER -- requirements
Module: oc_bank_arbiter

Interface
REQ-001 Parameter NUM_BANK, default 4, number of register-file banks; SHALL be fixed at 4.
REQ-002 Parameter ROW_W, default 6, bank row address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_vld  input  8  operand read request; bit i = requester ocid i = {cu[1:0], slot}.
REQ-006 req_bank  input  16  2-bit target bank per requester; bits [2i+1:2i].
REQ-007 req_row  input  8*ROW_W  row address per requester; bits [ROW_W*i +: ROW_W].
REQ-008 wb_bank_wr  input  4  writeback owns bank N this cycle.
REQ-009 gnt  output  8  one-cycle grant pulse per requester.
REQ-010 bk_rd_en  output  4  bank read enable to register file.
REQ-011 bk_rd_row  output  4*ROW_W  read row per bank.
REQ-012 bk_N_ocid (N=0..3)  output  3  owner of data on bank N, data-aligned.
REQ-013 bk_N_vld (N=0..3)  output  1  bank N data valid, data-aligned.
REQ-014 bk_N_bz (N=0..3)  output  1  bank N consumed by writeback, data-aligned.
REQ-015 same_OC_N (N=0..3)  output  1  bank N data also serves slot 1 of the same CU.

Function
REQ-016 Cycle t: each bank SHALL select one winner from requesters with req_vld[i]=1 and req_bank=N, not masked by REQ-020.
REQ-017 Selection SHALL be round-robin: search starts at pointer ptr_N (3 bits), ascending ocid, wrapping 7->0.
REQ-018 On a grant to ocid k, ptr_N SHALL become k+1 mod 8; with no grant, ptr_N SHALL be unchanged.
REQ-019 Cycle t+1: gnt[k]=1, bk_rd_en[N]=1, bk_rd_row[N]=req_row[k]; each output is registered.
REQ-020 A requester with gnt=1 in cycle t+1 SHALL be excluded from arbitration in t+1; this prevents a double grant while the requester drops req_vld.
REQ-021 Cycle t+2: bk_N_vld=1 and bk_N_ocid=k, aligned with bank read data.
REQ-022 If wb_bank_wr[N]=1 in cycle t, bank N SHALL grant nobody, ptr_N SHALL hold, and in t+2 bk_N_bz=1 and bk_N_vld=0.
REQ-023 At most one gnt bit per bank per cycle, except under REQ-031. One requester targets one bank, so gnt SHALL never double-count.
REQ-024 Banks SHALL arbitrate independently; four simultaneous grants to four different banks SHALL all issue in the same cycle.
REQ-025 When a bank has no valid request: bk_rd_en[N]=0 in t+1; bk_N_vld=0, bk_N_bz=0 and bk_N_ocid holds its previous value in t+2.
REQ-026 A request that is withdrawn before grant SHALL be dropped silently, with no state change.

Reset
REQ-027 While rst=0: gnt, bk_rd_en, all bk_N_vld, bk_N_bz and same_OC_N SHALL be 0; bk_rd_row and bk_N_ocid SHALL be 0; all ptr_N SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight t+1/t+2 pipeline entries; no vld pulse appears after reset release without a new grant.
REQ-029 The first arbitration SHALL occur on the first posedge after rst deasserts.

Configuration
REQ-030 Macro OC_ARB_SAMEOC_EN SHALL select operand-merge support.
REQ-031 With OC_ARB_SAMEOC_EN defined: if ocid {c,0} wins bank N and ocid {c,1} requests the same bank and the same row in that cycle, both gnt bits pulse together, and same_OC_N=1 in t+2 aligned with bk_N_vld. ptr_N advances past {c,1}.
REQ-032 Without OC_ARB_SAMEOC_EN: same_OC_N SHALL be tied 0, and the two requests SHALL be granted in separate cycles.

Verification
REQ-033 Bench SHALL cover: ocid 2 requests bank 1, row 5, at t -> gnt[2], bk_rd_en[1], bk_rd_row=5 at t+1; bk_1_vld=1, bk_1_ocid=2 at t+2.
REQ-034 Bench SHALL cover: all 8 requesters target bank 0 and hold until granted -> grants in ocid order 0..7, one per cycle, with no repeats; ptr_0 wraps to 0.
REQ-035 Bench SHALL cover: ocid 3 requests bank 2 while wb_bank_wr[2]=1 for one cycle -> bk_2_bz=1, bk_2_vld=0 at t+2; ocid 3 granted the next cycle.
REQ-036 Bench SHALL cover: ocids 0, 2, 4, 6 target banks 0, 1, 2, 3 simultaneously -> four grants in the same cycle, and bk_N_ocid equals 0, 2, 4, 6 respectively.
REQ-037 Bench SHALL cover: ocids 4 and 5 request bank 3, row 9 -> with the macro, gnt=8'h30 in one cycle and same_OC_3=1; without it, gnt[4] then gnt[5] in consecutive cycles.
REQ-038 Bench SHALL cover: rst pulled low in the cycle after a grant -> no bk_N_vld at t+2; all outputs are 0.

Source files
------------

// File: rtl/oc_bank_arbiter.sv
// rtl/oc_bank_arbiter.sv - per-bank round-robin operand-read arbiter; OC_ARB_SAMEOC_EN enables same-CU operand merge
module oc_bank_arbiter #(
    parameter int NUM_BANK = 4,
    parameter int ROW_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            req_vld,
    input  logic [15:0]           req_bank,
    input  logic [8*ROW_W-1:0]    req_row,
    input  logic [3:0]            wb_bank_wr,
    output logic [7:0]            gnt,
    output logic [3:0]            bk_rd_en,
    output logic [4*ROW_W-1:0]    bk_rd_row,
    output logic [2:0]            bk_0_ocid,
    output logic [2:0]            bk_1_ocid,
    output logic [2:0]            bk_2_ocid,
    output logic [2:0]            bk_3_ocid,
    output logic                  bk_0_vld,
    output logic                  bk_1_vld,
    output logic                  bk_2_vld,
    output logic                  bk_3_vld,
    output logic                  bk_0_bz,
    output logic                  bk_1_bz,
    output logic                  bk_2_bz,
    output logic                  bk_3_bz,
    output logic                  same_OC_0,
    output logic                  same_OC_1,
    output logic                  same_OC_2,
    output logic                  same_OC_3
);

    // grant stage (t+1)
    logic [7:0]                           gnt_q, gnt_d;
    logic [NUM_BANK-1:0]                  rd_en_q, rd_en_d;
    logic [NUM_BANK-1:0][ROW_W-1:0]       rd_row_q, rd_row_d;
    logic [NUM_BANK-1:0][2:0]             ptr_q, ptr_d;
    logic [NUM_BANK-1:0][2:0]             s1_ocid_q, s1_ocid_d;
    logic [NUM_BANK-1:0]                  s1_bz_q, s1_bz_d;
    // data-aligned stage (t+2)
    logic [NUM_BANK-1:0][2:0]             ocid_q;
    logic [NUM_BANK-1:0]                  vld_q;
    logic [NUM_BANK-1:0]                  bz_q;

    logic [7:0]                           elig;
    logic [3:0]                           pick;
    logic [2:0]                           win;
`ifdef OC_ARB_SAMEOC_EN
    logic [NUM_BANK-1:0]                  s1_same_q, s1_same_d;
    logic [NUM_BANK-1:0]                  same_q;
    logic [2:0]                           mate;
`endif

    // First eligible requester at or after ptr, wrapping 7->0; returns {found, ocid}
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int j = 7; j >= 0; j--) begin
            idx = ptr + 3'(j);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Per-bank arbitration; a requester granted last cycle is masked so it can drop req_vld
    always_comb begin
        gnt_d     = '0;
        rd_en_d   = '0;
        rd_row_d  = rd_row_q;
        ptr_d     = ptr_q;
        s1_ocid_d = s1_ocid_q;
        s1_bz_d   = '0;
        elig      = '0;
        pick      = '0;
        win       = '0;
`ifdef OC_ARB_SAMEOC_EN
        s1_same_d = '0;
        mate      = '0;
`endif
        for (int n = 0; n < NUM_BANK; n++) begin
            for (int i = 0; i < 8; i++) begin
                elig[i] = req_vld[i] && (req_bank[2*i +: 2] == 2'(n)) && !gnt_q[i];
            end
            pick       = rr_pick(elig, ptr_q[n]);
            s1_bz_d[n] = wb_bank_wr[n] && (|elig);
            if (pick[3] && !wb_bank_wr[n]) begin
                win          = pick[2:0];
                gnt_d[win]   = 1'b1;
                rd_en_d[n]   = 1'b1;
                rd_row_d[n]  = req_row[win*ROW_W +: ROW_W];
                ptr_d[n]     = win + 3'd1;
                s1_ocid_d[n] = win;
`ifdef OC_ARB_SAMEOC_EN
                // slot 0 winner pulls in slot 1 of the same CU reading the same row
                mate = {win[2:1], 1'b1};
                if (!win[0] && elig[mate] &&
                    (req_row[mate*ROW_W +: ROW_W] == req_row[win*ROW_W +: ROW_W])) begin
                    gnt_d[mate]  = 1'b1;
                    ptr_d[n]     = win + 3'd2;
                    s1_same_d[n] = 1'b1;
                end
`endif
            end
        end
    end

    // Grant-stage registers and round-robin pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q     <= '0;
            rd_en_q   <= '0;
            rd_row_q  <= '0;
            ptr_q     <= '0;
            s1_ocid_q <= '0;
            s1_bz_q   <= '0;
`ifdef OC_ARB_SAMEOC_EN
            s1_same_q <= '0;
`endif
        end else begin
            gnt_q     <= gnt_d;
            rd_en_q   <= rd_en_d;
            rd_row_q  <= rd_row_d;
            ptr_q     <= ptr_d;
            s1_ocid_q <= s1_ocid_d;
            s1_bz_q   <= s1_bz_d;
`ifdef OC_ARB_SAMEOC_EN
            s1_same_q <= s1_same_d;
`endif
        end
    end

    // Data-aligned stage; owner id holds when the bank is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            bz_q   <= '0;
            ocid_q <= '0;
`ifdef OC_ARB_SAMEOC_EN
            same_q <= '0;
`endif
        end else begin
            vld_q <= rd_en_q;
            bz_q  <= s1_bz_q;
            for (int n = 0; n < NUM_BANK; n++) begin
                if (rd_en_q[n]) ocid_q[n] <= s1_ocid_q[n];
            end
`ifdef OC_ARB_SAMEOC_EN
            same_q <= s1_same_q;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign bk_rd_en  = rd_en_q;
    assign bk_rd_row = rd_row_q;
    assign bk_0_ocid = ocid_q[0];
    assign bk_1_ocid = ocid_q[1];
    assign bk_2_ocid = ocid_q[2];
    assign bk_3_ocid = ocid_q[3];
    assign bk_0_vld  = vld_q[0];
    assign bk_1_vld  = vld_q[1];
    assign bk_2_vld  = vld_q[2];
    assign bk_3_vld  = vld_q[3];
    assign bk_0_bz   = bz_q[0];
    assign bk_1_bz   = bz_q[1];
    assign bk_2_bz   = bz_q[2];
    assign bk_3_bz   = bz_q[3];
`ifdef OC_ARB_SAMEOC_EN
    assign same_OC_0 = same_q[0];
    assign same_OC_1 = same_q[1];
    assign same_OC_2 = same_q[2];
    assign same_OC_3 = same_q[3];
`else
    assign same_OC_0 = 1'b0;
    assign same_OC_1 = 1'b0;
    assign same_OC_2 = 1'b0;
    assign same_OC_3 = 1'b0;
`endif

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// tb/tb_oc_bank_arbiter.sv - directed self-checking bench for oc_bank_arbiter
module tb_oc_bank_arbiter;

    localparam int ROW_W = 6;

    logic               clk;
    logic               rst;
    logic [7:0]         req_vld;
    logic [15:0]        req_bank;
    logic [8*ROW_W-1:0] req_row;
    logic [3:0]         wb_bank_wr;
    logic [7:0]         gnt;
    logic [3:0]         bk_rd_en;
    logic [4*ROW_W-1:0] bk_rd_row;
    logic [2:0]         bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid;
    logic               bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld;
    logic               bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz;
    logic               same_OC_0, same_OC_1, same_OC_2, same_OC_3;

    int n_tests = 0;
    int n_fail  = 0;

    oc_bank_arbiter #(.NUM_BANK(4), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_bank(req_bank), .req_row(req_row), .wb_bank_wr(wb_bank_wr),
        .gnt(gnt), .bk_rd_en(bk_rd_en), .bk_rd_row(bk_rd_row),
        .bk_0_ocid(bk_0_ocid), .bk_1_ocid(bk_1_ocid), .bk_2_ocid(bk_2_ocid), .bk_3_ocid(bk_3_ocid),
        .bk_0_vld(bk_0_vld), .bk_1_vld(bk_1_vld), .bk_2_vld(bk_2_vld), .bk_3_vld(bk_3_vld),
        .bk_0_bz(bk_0_bz), .bk_1_bz(bk_1_bz), .bk_2_bz(bk_2_bz), .bk_3_bz(bk_3_bz),
        .same_OC_0(same_OC_0), .same_OC_1(same_OC_1), .same_OC_2(same_OC_2), .same_OC_3(same_OC_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_flags();
        return {8'h0, gnt, bk_rd_en, bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
                bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz,
                same_OC_0, same_OC_1, same_OC_2, same_OC_3};
    endfunction

    function automatic logic [31:0] all_data();
        return {8'h0, bk_rd_row[23:0]} | {20'h0, bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid} << 24;
    endfunction

    initial begin
        logic [7:0] exp_g;
        rst = 1'b0; req_vld = '0; req_bank = '0; req_row = '0; wb_bank_wr = '0;
        tick; tick;
        check_eq("rst_flags", all_flags(), 32'h0);
        check_eq("rst_row", {8'h0, bk_rd_row}, 32'h0);
        check_eq("rst_ocid", {20'h0, bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid}, 32'h0);

        // ocid 2 -> bank 1 row 5, driven with reset release: first edge arbitrates
        rst = 1'b1;
        req_vld = 8'h04; req_bank[5:4] = 2'd1; req_row[2*ROW_W +: ROW_W] = 6'd5;
        tick;
        check_eq("single_gnt", {24'h0, gnt}, 32'h04);
        check_eq("single_rden", {28'h0, bk_rd_en}, 32'h2);
        check_eq("single_row", {26'h0, bk_rd_row[ROW_W +: ROW_W]}, 32'd5);
        req_vld = '0;
        tick;
        check_eq("single_vld", {31'h0, bk_1_vld}, 32'h1);
        check_eq("single_ocid", {29'h0, bk_1_ocid}, 32'd2);
        check_eq("single_gnt_off", {24'h0, gnt}, 32'h0);
        tick;

        // all 8 on bank 0, distinct rows; requesters drop once granted
        req_bank = '0;
        for (int i = 0; i < 8; i++) req_row[i*ROW_W +: ROW_W] = 6'(i + 1);
        req_vld = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            tick;
            exp_g = 8'h01 << c;
            check_eq($sformatf("rr_gnt%0d", c), {24'h0, gnt}, {24'h0, exp_g});
            if (c > 0) begin
                check_eq($sformatf("rr_ocid%0d", c), {28'h0, bk_0_vld, bk_0_ocid}, {28'h0, 1'b1, 3'(c - 1)});
            end
            req_vld = req_vld & ~exp_g;
        end
        tick;
        check_eq("rr_last_ocid", {28'h0, bk_0_vld, bk_0_ocid}, {28'h0, 4'hF});
        // pointer wrapped to 0: ocid 0 beats ocid 7
        req_vld = 8'h81;
        tick;
        check_eq("wrap_gnt0", {24'h0, gnt}, 32'h01);
        req_vld = 8'h80;
        tick;
        check_eq("wrap_gnt7", {24'h0, gnt}, 32'h80);
        req_vld = '0;
        tick; tick;

        // ocid 3 -> bank 2 blocked by writeback for one cycle
        req_bank = '0; req_bank[7:6] = 2'd2; req_vld = 8'h08; wb_bank_wr = 4'h4;
        tick;
        check_eq("wb_no_gnt", {24'h0, gnt}, 32'h0);
        check_eq("wb_no_rden", {28'h0, bk_rd_en}, 32'h0);
        wb_bank_wr = '0;
        tick;
        check_eq("wb_bz", {30'h0, bk_2_bz, bk_2_vld}, 32'h2);
        check_eq("wb_retry_gnt", {24'h0, gnt}, 32'h08);
        check_eq("wb_retry_rden", {28'h0, bk_rd_en}, 32'h4);
        req_vld = '0;
        tick;
        check_eq("wb_retry_vld", {27'h0, bk_2_bz, bk_2_vld, bk_2_ocid}, {27'h0, 2'b01, 3'd3});
        tick;

        // ocids 0,2,4,6 on banks 0..3 in parallel
        req_bank = '0;
        req_bank[1:0] = 2'd0; req_bank[5:4] = 2'd1; req_bank[9:8] = 2'd2; req_bank[13:12] = 2'd3;
        req_vld = 8'h55;
        tick;
        check_eq("par_gnt", {24'h0, gnt}, 32'h55);
        check_eq("par_rden", {28'h0, bk_rd_en}, 32'hF);
        req_vld = '0;
        tick;
        check_eq("par_vld", {28'h0, bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld}, 32'hF);
        check_eq("par_ocid", {20'h0, bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid}, {20'h0, 3'd0, 3'd2, 3'd4, 3'd6});
        tick;
        check_eq("idle_hold", {28'h0, bk_1_vld, bk_1_ocid}, {28'h0, 1'b0, 3'd2});

        // ocids 4 and 5 on bank 3, same row 9
        req_bank = '0; req_bank[9:8] = 2'd3; req_bank[11:10] = 2'd3;
        req_row[4*ROW_W +: ROW_W] = 6'd9; req_row[5*ROW_W +: ROW_W] = 6'd9;
        req_vld = 8'h30;
`ifdef OC_ARB_SAMEOC_EN
        tick;
        check_eq("merge_gnt", {24'h0, gnt}, 32'h30);
        req_vld = '0;
        tick;
        check_eq("merge_same", {27'h0, same_OC_3, bk_3_vld, bk_3_ocid}, {27'h0, 2'b11, 3'd4});
`else
        tick;
        check_eq("split_gnt4", {24'h0, gnt}, 32'h10);
        req_vld = 8'h20;
        tick;
        check_eq("split_gnt5", {24'h0, gnt}, 32'h20);
        check_eq("split_ocid4", {27'h0, same_OC_3, bk_3_vld, bk_3_ocid}, {27'h0, 2'b01, 3'd4});
        req_vld = '0;
        tick;
        check_eq("split_ocid5", {27'h0, same_OC_3, bk_3_vld, bk_3_ocid}, {27'h0, 2'b01, 3'd5});
`endif
        tick;

        // reset in the cycle after a grant flushes the pipeline
        req_bank = '0; req_row[1*ROW_W +: ROW_W] = 6'd3; req_vld = 8'h02;
        tick;
        check_eq("rst_pre_gnt", {24'h0, gnt}, 32'h02);
        rst = 1'b0; req_vld = '0;
        #2;
        check_eq("rst_mid_flags", all_flags(), 32'h0);
        tick;
        rst = 1'b1;
        tick;
        check_eq("rst_post_flags", all_flags(), 32'h0);
        check_eq("rst_post_data", all_data(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
